// File: rtl/rr_encoder_arbiter.sv
// ---------------------------------------------------------------------------
// rr_encoder_arbiter
//   Round-robin arbiter sharing one downstream resource between N requesters.
//   A rotating-mask priority encode picks the next owner; the one-hot grant is
//   held until the owner signals done, drops its request, or the hold timeout
//   expires. On release the grant moves straight to the next requester with no
//   idle bubble, excluding the owner that just released.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_i[N]     level-sensitive request vector
//   done_i       current owner finished (only looked at while BUSY)
//   grant_o[N]   registered one-hot grant, zero when idle
//   grant_val_o  grant_o is non-zero
//   grant_idx_o  binary index of the granted bit, zero when idle
//   timeout_o    one-cycle pulse after a grant is revoked by the timeout
// ---------------------------------------------------------------------------
module rr_encoder_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_i,
    input  logic                 done_i,
    output logic [N-1:0]         grant_o,
    output logic                 grant_val_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 timeout_o
);

    localparam int IW = $clog2(N);
    // Counter only ever reaches MAX_HOLD-1, so this width never wraps before
    // the compare. Keep one bit when the timeout is disabled.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            timeout_q, timeout_d;

    logic            own_req;
    logic            hold_hit;
    logic            release_now;
    logic [IW-1:0]   nxt_ptr;
    logic [N-1:0]    cand;
    logic [N-1:0]    pick;

    // First set bit of req at or above ptr; wraps to the lowest set bit when
    // nothing at or above ptr is requesting.
    function automatic logic [N-1:0] sel_rr(input logic [N-1:0] req,
                                            input logic [IW-1:0] ptr);
        logic [N-1:0] masked;
        logic [N-1:0] x;
        masked = req & ~((N'(1) << ptr) - N'(1));
        x      = (masked != '0) ? masked : req;
        return x & (~x + N'(1));
    endfunction

    // Argument is one-hot or zero, so OR-ing indices is an exact encode.
    function automatic logic [IW-1:0] enc(input logic [N-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (oh[k]) r = r | IW'(k);
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        grant_d     = grant_q;
        timeout_d   = 1'b0;
        own_req     = |(req_i & grant_q);
        hold_hit    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
        release_now = 1'b0;
        nxt_ptr     = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        cand        = '0;
        pick        = '0;

        case (state_q)
            IDLE: begin
                if (req_i != '0) begin
                    grant_d = sel_rr(req_i, ptr_q);
                    hold_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                release_now = done_i | ~own_req | hold_hit;
                if (release_now) begin
                    ptr_d     = nxt_ptr;
                    // The releasing owner sits out this pick.
                    cand      = req_i & ~grant_q;
                    pick      = sel_rr(cand, nxt_ptr);
                    grant_d   = pick;
                    hold_d    = '0;
                    state_d   = (pick != '0) ? BUSY : IDLE;
                    // done wins the reporting when it coincides with timeout.
                    timeout_d = hold_hit & ~done_i;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        idx_d = enc(grant_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_val_o = |grant_q;
    assign grant_idx_o = idx_q;
    assign timeout_o   = timeout_q;

endmodule

// File: doc/rr_encoder_arbiter.md
Name: rr_encoder_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (encoder datapath / bus slot) between N requesters.
- Uses a rotating-mask priority encode to pick the next requester. Holds a one-hot grant until the owner releases it, abandons it, or a hold timeout fires.
- Sits between request sources and the shared priority-encoder datapath; grant_idx_o steers the shared mux.

Parameters:
- N, 8, number of requesters (2..32).
- MAX_HOLD, 16, maximum cycles a grant may be held. 0 disables the timeout.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  N  request vector, bit k = requester k wants the resource; level-sensitive.
- done_i  in  1  current owner finished; sampled only in BUSY.
- grant_o  out  N  one-hot grant, registered; all-zero when idle.
- grant_val_o  out  1  high when grant_o is non-zero.
- grant_idx_o  out  $clog2(N)  binary index of the granted bit; 0 when idle.
- timeout_o  out  1  one-cycle pulse when a grant is revoked by the timeout.

Behaviour:
- Reset (rst_ni=0, async):
  - grant_o='0, grant_val_o=0, grant_idx_o=0, timeout_o=0.
  - state=IDLE, ptr=0 (requester 0 highest priority), hold_cnt=0.
- Selection function sel(req, ptr):
  - First set bit of req scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1, with modulo-N wrap.
  - Implement as masked encode (req & ~((1<<ptr)-1)); if that is zero, fall back to the unmasked encode.
  - Isolate the lowest set bit with x & (~x+1).
- State IDLE:
  - If req_i != 0: next edge grant_o=onehot(sel), grant_idx_o=sel, grant_val_o=1, hold_cnt=0, go to BUSY.
  - Latency: 1 cycle from req_i to grant_o.
  - If req_i == 0: outputs stay at their zero values.
- State BUSY, owner g. Release conditions, evaluated each cycle:
  - (a) done_i=1.
  - (b) req_i[g]=0 (abandon).
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (timeout).
- Any condition true is a single release, even if several are true together.
- In the release cycle:
  - ptr <= (g+1) mod N.
  - Next owner = sel(req_i & ~onehot(g), (g+1) mod N); the released requester is excluded for this pick.
  - If a next owner exists: grant_o switches directly to it at the next edge (no bubble), hold_cnt=0, stay BUSY.
  - If no next owner exists: grant_o=0, grant_val_o=0, grant_idx_o=0, go to IDLE.
- No release: grant_o held unchanged, hold_cnt increments.
  - hold_cnt width is $clog2(MAX_HOLD+1) and must not wrap before the compare.
- timeout_o:
  - Registered and asserted for exactly the cycle after a release caused by (c) alone or together with others.
  - If done_i and the timeout coincide, timeout_o=0 (done has precedence for reporting).
- Invariants:
  - grant_o always one-hot or zero.
  - grant_idx_o always consistent with grant_o.
  - A granted bit always had req_i set in the cycle the decision was made.
- req_i changes on non-owner bits during BUSY do not affect the current grant.
- A requester that timed out may re-win only after all other active requesters have had a turn.
- Reset mid-BUSY: outputs clear immediately (async) and ptr returns to 0.
- Fairness: with all N bits constantly requesting and done_i pulsed once per grant, grants cycle 0,1,...,N-1,0,...

Test Plan:
- Reset/idle: rst_ni=0 then 1, req_i=0 for 10 cycles -> grant_o=0, grant_val_o=0, grant_idx_o=0, timeout_o=0 throughout.
- Single request: N=4, req_i=4'b0100 at cycle t -> grant_o=4'b0100, grant_idx_o=2 at t+1. done_i at t+3 -> grant_o=0 at t+4.
- Round-robin: req_i=4'b1111 held, done_i pulsed on each grant's 2nd cycle -> grant_idx_o sequence 0,1,2,3,0 with no idle cycle between grants.
- Wrap and exclusion: ptr=3 after granting 2, req_i=4'b0101, done_i -> next grant is idx 0 (wrap), then idx 2 after the following done.
- Timeout: MAX_HOLD=16, req_i=4'b0010 held, done_i=0 -> grant revoked after 16 grant cycles, timeout_o pulses once. Since bit 1 is the only requester, the arbiter returns to IDLE, then re-grants 1 cycle later.
- Abandon and async reset: owner drops req_i -> grant moves to the next requester at the next edge. rst_ni=0 asserted mid-grant -> grant_o=0 without waiting for a clock edge.
